// File: rtl/phys_reg_free_list.sv
// Rename-stage free list of physical destination tags, with a single branch
// checkpoint that rolls back allocation on mispredict.
module phys_reg_free_list #(
    parameter int unsigned NUM_PREGS = 128,
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned TAG_W     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_req,
    output logic                 alloc_valid,
    output logic [TAG_W-1:0]     alloc_preg,
    input  logic                 free_valid,
    input  logic [TAG_W-1:0]     free_preg,
    input  logic                 ckpt_save,
    input  logic                 ckpt_clear,
    input  logic                 mispredict,
    output logic                 ckpt_valid,
    output logic [NUM_PREGS-1:0] ckpt_mask,
    output logic [7:0]           free_count,
    output logic                 empty,
    output logic                 overflow_err
);

    localparam int unsigned DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int unsigned CNT_W = 8;
    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TAG_W-1:0]     entries [DEPTH];
    logic [TAG_W-1:0]     head, head_n;
    logic [TAG_W-1:0]     tail, tail_n;
    logic [TAG_W-1:0]     saved_head, saved_head_n;
    logic [CNT_W-1:0]     count, count_n;
    logic [CNT_W-1:0]     since_cnt, since_n;
    logic                 ckpt_valid_n;
    logic [NUM_PREGS-1:0] ckpt_mask_n;
    logic                 mask_hold, mask_hold_n;
    logic                 overflow_n;

    logic                 grant;
    logic                 rollback;
    logic [CNT_W-1:0]     count_eff;
    logic                 free_ok;
    logic                 free_full;
    logic [TAG_W-1:0]     head_inc;
    logic [TAG_W-1:0]     tail_inc;

    // Handshake is same-cycle: rename consumes alloc_preg when it is granted.
    assign alloc_valid = (count != '0) && !mispredict;
    assign alloc_preg  = entries[head];
    assign free_count  = count;

    always_comb begin
        grant     = alloc_req && alloc_valid;
        rollback  = mispredict && ckpt_valid;
        count_eff = count - CNT_W'(grant);
        free_ok   = free_valid && (free_preg != '0) && (count_eff < FULL_CNT);
        free_full = free_valid && (free_preg != '0) && (count_eff >= FULL_CNT);
        // Depth is not a power of two, so both pointers wrap explicitly.
        head_inc  = (head == LAST_IDX) ? '0 : head + TAG_W'(1);
        tail_inc  = (tail == LAST_IDX) ? '0 : tail + TAG_W'(1);
    end

    // Next-state for pointers, count and checkpoint.
    always_comb begin
        head_n       = head;
        tail_n       = tail;
        count_n      = count;
        saved_head_n = saved_head;
        since_n      = since_cnt;
        ckpt_valid_n = ckpt_valid;
        ckpt_mask_n  = mask_hold ? '0 : ckpt_mask;
        mask_hold_n  = 1'b0;
        overflow_n   = overflow_err | free_full;

        if (free_ok) begin
            tail_n = tail_inc;
        end

        if (rollback) begin
            // Tags handed out since the branch become free again; the mask
            // stays visible one more cycle for the register file.
            head_n       = saved_head;
            count_n      = count + since_cnt + CNT_W'(free_ok);
            ckpt_valid_n = 1'b0;
            since_n      = '0;
            ckpt_mask_n  = ckpt_mask;
            mask_hold_n  = 1'b1;
        end else begin
            if (grant) begin
                head_n = head_inc;
            end
            count_n = count_eff + CNT_W'(free_ok);

            if (mispredict) begin
                // No checkpoint to roll back to: only the grant is suppressed.
            end else if (ckpt_save) begin
                // Snapshot after this cycle's grant so the branch keeps its rd.
                saved_head_n = head_n;
                since_n      = '0;
                ckpt_mask_n  = '0;
                ckpt_valid_n = 1'b1;
            end else if (ckpt_clear) begin
                ckpt_valid_n = 1'b0;
                ckpt_mask_n  = '0;
            end else if (grant && ckpt_valid) begin
                ckpt_mask_n[alloc_preg] = 1'b1;
                since_n                 = since_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            saved_head   <= '0;
            count        <= FULL_CNT;
            since_cnt    <= '0;
            ckpt_valid   <= 1'b0;
            ckpt_mask    <= '0;
            mask_hold    <= 1'b0;
            overflow_err <= 1'b0;
            empty        <= 1'b0;
        end else begin
            head         <= head_n;
            tail         <= tail_n;
            saved_head   <= saved_head_n;
            count        <= count_n;
            since_cnt    <= since_n;
            ckpt_valid   <= ckpt_valid_n;
            ckpt_mask    <= ckpt_mask_n;
            mask_hold    <= mask_hold_n;
            overflow_err <= overflow_n;
            empty        <= (count_n == '0);
        end
    end

    // Tag storage; reset maps every non-architectural tag into the list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= TAG_W'(NUM_AREGS + i);
            end
        end else if (free_ok) begin
            entries[tail] <= free_preg;
        end
    end

endmodule
